serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial subtractor. Computes A − B − Bin one bit per clock, LSB first, using a single registered full-subtractor cell. It is the inverse-direction companion to the combinational full adder. It sits beside the adder blocks as the area-cheap arithmetic path, with a start/busy/done handshake toward the controlling logic.

## Interface

Parameters:
- WIDTH, default 8: operand and result width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request a new subtraction; sampled on the rising edge of clk.
- A  input  WIDTH  minuend; sampled only on an accepted start.
- B  input  WIDTH  subtrahend; sampled only on an accepted start.
- Bin  input  1  borrow-in; sampled only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is written.
- D  output  WIDTH  difference; held until the next completion.
- Bout  output  1  borrow-out of the MSB; held with D.
- Z  output  1  high when D == 0; held with D.

## Operation

- States: IDLE, RUN, DONE.
- IDLE, start=1: latch A, B and Bin into shift registers; clear the bit counter; go to RUN.
- RUN: each cycle, consume bit a=A_sh[0] and b=B_sh[0] with the running borrow br:
  - d = a ^ b ^ br
  - br_next = (~a & b) | (~(a ^ b) & br)
  - shift d into the result register from the MSB end; shift the operands right; increment the counter.
- RUN, last bit (counter == WIDTH−1): write D, Bout=br_next and Z=(result==0) on that edge; go to DONE.
- DONE: lasts one cycle with done=1. start=1 in DONE is accepted exactly as in IDLE (go to RUN). Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not resampled.
- Arithmetic: {Bout, D} equals A − B − Bin modulo 2^(WIDTH+1) when read as unsigned. Equivalently, Bout=1 if and only if A < B + Bin (unsigned), and D = (A − B − Bin) mod 2^WIDTH.
- D, Bout and Z change only on a completion edge or on reset.
- Reset (asynchronous, any state): state goes to IDLE, and busy, done, D, Bout, Z and all internal registers go to 0. A reset mid-operation aborts the subtraction, and no done is produced for it.

## Timing

- Reset values: busy=0, done=0, D=0, Bout=0, Z=0.
  - Z stays 0 after reset until the first completion. It is not derived combinationally from D.
- start is accepted at edge E0. busy=1 from E0 through edge E0+WIDTH, which is exactly WIDTH cycles.
- The result registers update at edge E0+WIDTH. done=1 for the cycle between edges E0+WIDTH and E0+WIDTH+1. busy=0 in that cycle.
- Latency from start edge to done: WIDTH cycles.
- Minimum issue interval: WIDTH+1 cycles, with start held high or re-asserted in the DONE cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- Basic (WIDTH=8): rst pulse, then start with A=100, B=58, Bin=0.
  - Expect: busy high 8 cycles, done 8 cycles after the start edge, D=42, Bout=0, Z=0.
- Negative result: A=5, B=9, Bin=0.
  - Expect: D=252, Bout=1, Z=0.
- Borrow-in edges:
  - A=0, B=0, Bin=1 → D=255, Bout=1.
  - A=7, B=7, Bin=0 → D=0, Bout=0, Z=1.
  - A=255, B=0, Bin=1 → D=254, Bout=0.
- Handshake:
  - Pulse start at cycles 2 and 5 of a run with changed A/B: ignored, and the result matches the original operands.
  - Hold start high through DONE: the second operation begins the cycle after done, with the issue interval = 9.
- Reset mid-operation: assert rst asynchronously (between edges) during cycle 4 of RUN.
  - Expect: busy, done, D, Bout and Z all 0 immediately; no done afterward; the next start completes normally.
- Sweep: WIDTH=4, all 512 combinations of A, B and Bin. Compare {Bout, D} against the model (A − B − Bin) & 5'h1F and check Z, with done on every run.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//
// Handshake and data bundle for the bit-serial subtractor.
// The controlling logic uses the master side. The subtractor uses the slave side.
//
//   start  master -> slave  request a new subtraction
//   A      master -> slave  minuend, WIDTH bits
//   B      master -> slave  subtrahend, WIDTH bits
//   Bin    master -> slave  borrow-in
//   busy   slave -> master  high while bits are being processed
//   done   slave -> master  one-cycle pulse when the result is written
//   D      slave -> master  difference, WIDTH bits, held until the next completion
//   Bout   slave -> master  borrow-out of the MSB, held with D
//   Z      slave -> master  D == 0, held with D
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             Z;

    modport master (
        output start, A, B, Bin,
        input  busy, done, D, Bout, Z
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, D, Bout, Z
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//
// Bit-serial subtractor. It computes A - B - Bin one bit per clock, starting
// with the LSB, using a single registered full-subtractor cell.
// A start accepted at edge E0 produces the result and a done pulse at edge E0+WIDTH.
//
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  serial_subtractor_if.slave
//        inputs:  start, A, B, Bin
//        outputs: busy, done, D, Bout, Z
//        All outputs are registered.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Full-subtractor cell working on the current LSBs and the running borrow.
    // Each result bit enters at the MSB end. After WIDTH shifts, the first bit
    // computed (the LSB) has reached bit 0.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
        res_next = {d_bit, res_sh[WIDTH-1:1]};
        last_bit = (cnt == CNT_W'(WIDTH - 1));
    end

    // Control FSM and datapath.
    // IDLE and DONE both accept a new start. This allows back-to-back operations
    // with an issue interval of WIDTH+1 cycles. The visible result registers are
    // written only on the last RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.D    <= '0;
            bus.Bout <= 1'b0;
            bus.Z    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        a_sh     <= bus.A;
                        b_sh     <= bus.B;
                        br       <= bus.Bin;
                        res_sh   <= '0;
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end else begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    res_sh <= res_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        bus.D    <= res_next;
                        bus.Bout <= br_next;
                        bus.Z    <= (res_next == '0);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//
// Directed testbench for serial_subtractor.
// It instantiates one 8-bit DUT and one 4-bit DUT. Both share clk and rst.
// Outputs are sampled on the falling edge.
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Issue one 8-bit operation.
    // It returns the number of edges from the start edge to the first done
    // sample, and the number of sampled cycles with busy high.
    // The return is bounded at 40 edges.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output int lat, output int busy_cnt);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A     = a;
        bus8.B     = b;
        bus8.Bin   = bin;
        @(negedge clk);
        bus8.start = 1'b0;
        lat        = 0;
        busy_cnt   = 0;
        while (!bus8.done && lat < 40) begin
            if (bus8.busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output int lat);
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.A     = a;
        bus4.B     = b;
        bus4.Bin   = bin;
        @(negedge clk);
        bus4.start = 1'b0;
        lat        = 0;
        while (!bus4.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus8.busy, bus8.done, bus8.D, bus8.Bout, bus8.Z} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL reset8: got busy=%b done=%b D=%0d Bout=%b Z=%b expected all 0",
                     bus8.busy, bus8.done, bus8.D, bus8.Bout, bus8.Z);
        end
        total++;
        if ({bus4.busy, bus4.done, bus4.D, bus4.Bout, bus4.Z} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset4: got busy=%b done=%b D=%0d Bout=%b Z=%b expected all 0",
                     bus4.busy, bus4.done, bus4.D, bus4.Bout, bus4.Z);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus8.Z !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_z_hold: got Z=%b expected 0", bus8.Z);
        end
    endtask

    task automatic test_basic();
        int lat, busy_cnt;
        run8(8'd100, 8'd58, 1'b0, lat, busy_cnt);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("[TB] FAIL basic_latency: got %0d expected 8", lat);
        end
        total++;
        if (busy_cnt !== 8) begin
            bad++;
            $display("[TB] FAIL basic_busy: got %0d cycles expected 8", busy_cnt);
        end
        total++;
        if ({bus8.D, bus8.Bout, bus8.Z, bus8.busy} !== {8'd42, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL basic_result: got D=%0d Bout=%b Z=%b busy=%b expected D=42 Bout=0 Z=0 busy=0",
                     bus8.D, bus8.Bout, bus8.Z, bus8.busy);
        end
        @(negedge clk);
        total++;
        if (bus8.done !== 1'b0 || bus8.D !== 8'd42) begin
            bad++;
            $display("[TB] FAIL basic_pulse: got done=%b D=%0d expected done=0 D=42", bus8.done, bus8.D);
        end
    endtask

    task automatic test_negative();
        int lat, busy_cnt;
        run8(8'd5, 8'd9, 1'b0, lat, busy_cnt);
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd252, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL negative: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=252 Bout=1 Z=0",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
    endtask

    task automatic test_borrow_edges();
        int lat, busy_cnt;
        run8(8'd0, 8'd0, 1'b1, lat, busy_cnt);
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd255, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL bin_zero: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=255 Bout=1 Z=0",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
        run8(8'd7, 8'd7, 1'b0, lat, busy_cnt);
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL equal_zero: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=0 Bout=0 Z=1",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
        run8(8'd255, 8'd0, 1'b1, lat, busy_cnt);
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd254, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL max_bin: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=254 Bout=0 Z=0",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
    endtask

    // A start pulse during RUN carries different operands.
    // The result must still come from the original operands: 200 - 73 = 127.
    task automatic test_ignore_start();
        int lat;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A     = 8'd200;
        bus8.B     = 8'd73;
        bus8.Bin   = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        lat        = 0;
        while (!bus8.done && lat < 40) begin
            if (lat == 2 || lat == 5) begin
                bus8.start = 1'b1;
                bus8.A     = 8'd1;
                bus8.B     = 8'd2;
                bus8.Bin   = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        bus8.start = 1'b0;
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd127, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL ignore_start: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=127 Bout=0 Z=0",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
        @(negedge clk);
        total++;
        if (bus8.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ignore_start_idle: got busy=%b expected 0", bus8.busy);
        end
    endtask

    // start is held high through DONE. The second operation must be accepted on
    // the edge that ends the DONE cycle.
    // Expected results: 10 - 3 = 7, then 3 - 10 = -7, which reads as 249 with Bout=1.
    task automatic test_back_to_back();
        int          lat, t1, t2;
        logic [7:0]  d1;
        logic        b1;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A     = 8'd10;
        bus8.B     = 8'd3;
        bus8.Bin   = 1'b0;
        @(negedge clk);
        lat = 0;
        t1  = -1;
        t2  = -1;
        d1  = '0;
        b1  = 1'b0;
        while (t2 < 0 && lat < 60) begin
            if (bus8.done) begin
                if (t1 < 0) begin
                    t1      = lat;
                    d1      = bus8.D;
                    b1      = bus8.Bout;
                    bus8.A  = 8'd3;
                    bus8.B  = 8'd10;
                end else begin
                    t2         = lat;
                    bus8.start = 1'b0;
                end
            end
            if (t2 < 0) begin
                @(negedge clk);
                lat++;
            end
        end
        bus8.start = 1'b0;
        total++;
        if (t1 !== 8 || d1 !== 8'd7 || b1 !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_first: got t=%0d D=%0d Bout=%b expected t=8 D=7 Bout=0", t1, d1, b1);
        end
        total++;
        if (t2 - t1 !== 9) begin
            bad++;
            $display("[TB] FAIL b2b_interval: got %0d expected 9", t2 - t1);
        end
        total++;
        if ({bus8.D, bus8.Bout, bus8.Z} !== {8'd249, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL b2b_second: got D=%0d Bout=%b Z=%b expected D=249 Bout=1 Z=0",
                     bus8.D, bus8.Bout, bus8.Z);
        end
        @(negedge clk);
    endtask

    // Reset is asserted between edges in the fourth RUN cycle.
    // The previous result was 249, so it must read back as 0.
    task automatic test_reset_midop();
        int lat, busy_cnt, seen;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.A     = 8'd90;
        bus8.B     = 8'd33;
        bus8.Bin   = 1'b0;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.D, bus8.Bout, bus8.Z} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL midop_reset: got busy=%b done=%b D=%0d Bout=%b Z=%b expected all 0",
                     bus8.busy, bus8.done, bus8.D, bus8.Bout, bus8.Z);
        end
        #1 rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done || bus8.busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("[TB] FAIL midop_no_done: got %0d active cycles expected 0", seen);
        end
        run8(8'd50, 8'd20, 1'b1, lat, busy_cnt);
        total++;
        if (lat !== 8 || {bus8.D, bus8.Bout, bus8.Z} !== {8'd29, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL midop_recover: got lat=%0d D=%0d Bout=%b Z=%b expected lat=8 D=29 Bout=0 Z=0",
                     lat, bus8.D, bus8.Bout, bus8.Z);
        end
    endtask

    // Exhaustive sweep on the 4-bit instance.
    task automatic test_sweep();
        int         lat;
        logic [4:0] expect_v;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bin = 0; bin < 2; bin++) begin
                    expect_v = 5'((a - b - bin) & 'h1F);
                    run4(4'(a), 4'(b), 1'(bin), lat);
                    total++;
                    if (lat !== 4 || {bus4.Bout, bus4.D} !== expect_v) begin
                        bad++;
                        $display("[TB] FAIL sweep a=%0d b=%0d bin=%0d: got lat=%0d {Bout,D}=%0d expected lat=4 {Bout,D}=%0d",
                                 a, b, bin, lat, {bus4.Bout, bus4.D}, expect_v);
                    end
                    total++;
                    if (bus4.Z !== (expect_v[3:0] == 4'd0)) begin
                        bad++;
                        $display("[TB] FAIL sweep_z a=%0d b=%0d bin=%0d: got %b expected %b",
                                 a, b, bin, bus4.Z, (expect_v[3:0] == 4'd0));
                    end
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.A     = '0;
        bus8.B     = '0;
        bus8.Bin   = 1'b0;
        bus4.start = 1'b0;
        bus4.A     = '0;
        bus4.B     = '0;
        bus4.Bin   = 1'b0;
        test_reset();
        test_basic();
        test_negative();
        test_borrow_edges();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
